apb_slave_regfile: RTL and testbench

APB responder at the far end of the AHB-to-APB bridge's controller interface: it decodes one slave-select line, runs the setup/access handshake with a programmable number of wait states, and services reads and writes to a 16-entry, 32-bit register file. Illegal accesses are reported on Pslverr, and register 0 is exported to downstream logic. One instance sits on each of the three Pselx lines.

---
 rtl/apb_slave_regfile.sv | 149 ++++++++++++++
 tb/tb_apb_slave_regfile.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regfile.sv
// APB responder with a 16-entry, 32-bit register file.
// It decodes one Pselx line and runs the setup/access handshake with a
// fixed number of wait states. Illegal transfers complete with Pslverr.
// Register 15 is a read-only ID word. Register 0 is exported on Regout.
module apb_slave_regfile #(
  parameter int          SEL_BIT     = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr,
  output logic [31:0] Regout
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [3:0]  idx_q, idx_d;
  logic        legal_q, legal_d;
  logic [31:0] rdata_q, rdata_d;

  // Storage for the writable registers 0..14.
  logic [31:0] reg_q [0:14];

  // Read view of the whole 16-word window, with the ID word in slot 15.
  logic [31:0] rd_word [0:15];

  logic        sel;
  logic [3:0]  addr_idx;
  logic        addr_legal;
  logic        complete;
  logic        wr_en;

  assign sel      = Pselx[SEL_BIT];
  assign addr_idx = Paddr[5:2];

  // Legal only inside the 64-byte window, word aligned, and not a write to the ID word.
  assign addr_legal = (Paddr[31:6] == BASE_ADDR[31:6]) &&
                      (Paddr[1:0] == 2'b00) &&
                      !(Pwrite && (addr_idx == 4'd15));

  genvar gi;
  generate
    for (gi = 0; gi < 15; gi++) begin : g_rd_word
      assign rd_word[gi] = reg_q[gi];
    end
  endgenerate
  assign rd_word[15] = ID_VALUE;

  // The completion edge is the access cycle in which the wait counter has run out.
  assign complete = (state_q == ACCESS) && (cnt_q == 4'd0) && sel && Penable;
  assign wr_en    = complete && write_q && legal_q;

  // Next-state logic: capture the transfer at setup, count wait states, finish or abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    legal_d = legal_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        // Penable without a preceding setup cycle is ignored here.
        if (sel && !Penable) begin
          state_d = ACCESS;
          cnt_d   = WAIT_LOAD;
          write_d = Pwrite;
          idx_d   = addr_idx;
          legal_d = addr_legal;
          rdata_d = (addr_legal && !Pwrite) ? rd_word[addr_idx] : 32'h0;
        end
      end
      ACCESS: begin
        if (!sel) begin
          // Slave deselected mid-transfer: drop it without touching the registers.
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (Penable) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Transfer state register; reset drops any transfer in flight.
  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      idx_q   <= 4'd0;
      legal_q <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      legal_q <= legal_d;
      rdata_q <= rdata_d;
    end
  end

  // Register file update: a legal write commits Pwdata on its completion edge.
  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      for (int i = 0; i < 15; i++) begin
        reg_q[i] <= 32'h0;
      end
    end else if (wr_en && (idx_q != 4'd15)) begin
      reg_q[idx_q] <= Pwdata;
    end
  end

  // Response outputs are held low while reset is asserted.
  always_comb begin
    Pready  = complete && Hresetn;
    Pslverr = Pready && !legal_q;
    Prdata  = (Pready && !write_q) ? rdata_q : 32'h0;
  end

  assign Regout = reg_q[0];

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: two instances on one bus,
// dut0 on Pselx[0] with no wait states, dut1 on Pselx[1] with three.
module tb_apb_slave_regfile;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [2:0]  pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;

  logic [31:0] prdata0, prdata1, regout0, regout1;
  logic        pready0, pready1, pslverr0, pslverr1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;

  apb_slave_regfile #(.SEL_BIT(0), .BASE_ADDR(32'h8000_0000), .WAIT_CYCLES(0), .ID_VALUE(32'hA9B0_0001)) dut0 (
    .Hclk(hclk), .Hresetn(hresetn), .Pselx(pselx), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata0), .Pready(pready0), .Pslverr(pslverr0),
    .Regout(regout0)
  );

  apb_slave_regfile #(.SEL_BIT(1), .BASE_ADDR(32'h8000_0000), .WAIT_CYCLES(3), .ID_VALUE(32'hA9B0_0001)) dut1 (
    .Hclk(hclk), .Hresetn(hresetn), .Pselx(pselx), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata1), .Pready(pready1), .Pslverr(pslverr1),
    .Regout(regout1)
  );

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive_idle();
    pselx   = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'h0;
    pwdata  = 32'h0;
  endtask

  // Runs one transfer and reports what the chosen instance did; never compares.
  // nwait is the number of access cycles before Pready, or -1 if Pready never came.
  task automatic xfer(input int which, input logic [2:0] sel3, input logic wr,
                      input logic [31:0] addr, input logic [31:0] data, input bit idle_after,
                      output logic setup_rdy, output int nwait, output logic [31:0] rdata,
                      output logic err, output int rdy_cyc);
    logic rdy;
    pselx   = sel3;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    @(negedge hclk);
    setup_rdy = (which == 0) ? pready0 : pready1;
    step();
    penable = 1'b1;
    nwait   = -1;
    rdata   = 32'h0;
    err     = 1'b0;
    rdy_cyc = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge hclk);
      rdy = (which == 0) ? pready0 : pready1;
      if (rdy) begin
        nwait   = k;
        rdata   = (which == 0) ? prdata0 : prdata1;
        err     = (which == 0) ? pslverr0 : pslverr1;
        rdy_cyc = cyc;
        break;
      end
      step();
    end
    if (nwait >= 0) step();
    if (idle_after) drive_idle();
  endtask

  task automatic test_reset();
    hresetn = 1'b0;
    drive_idle();
    step();
    step();
    @(negedge hclk);
    checks++; if (pready0 !== 1'b0) begin errors++; $display("FAIL reset_pready0 got=%b exp=0", pready0); end
    checks++; if (pslverr0 !== 1'b0) begin errors++; $display("FAIL reset_pslverr0 got=%b exp=0", pslverr0); end
    checks++; if (prdata0 !== 32'h0) begin errors++; $display("FAIL reset_prdata0 got=%h exp=0", prdata0); end
    checks++; if (regout0 !== 32'h0) begin errors++; $display("FAIL reset_regout0 got=%h exp=0", regout0); end
    checks++; if (pready1 !== 1'b0) begin errors++; $display("FAIL reset_pready1 got=%b exp=0", pready1); end
    step();
    hresetn = 1'b1;
    step();
    $display("reset: done");
  endtask

  task automatic test_write_read();
    logic sr, er; int nw, rc; logic [31:0] rd;
    xfer(0, 3'b001, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 1'b1, sr, nw, rd, er, rc);
    $display("write 80000000 <= deadbeef: nwait=%0d err=%b", nw, er);
    checks++; if (sr !== 1'b0) begin errors++; $display("FAIL wr_setup_ready got=%b exp=0", sr); end
    checks++; if (nw !== 0) begin errors++; $display("FAIL wr_nwait got=%0d exp=0", nw); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err got=%b exp=0", er); end
    @(negedge hclk);
    checks++; if (regout0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_regout got=%h exp=deadbeef", regout0); end
    step();
    xfer(0, 3'b001, 1'b0, 32'h8000_0000, 32'h0, 1'b1, sr, nw, rd, er, rc);
    $display("read 80000000: data=%h nwait=%0d err=%b", rd, nw, er);
    checks++; if (nw !== 0) begin errors++; $display("FAIL rd_nwait got=%0d exp=0", nw); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err got=%b exp=0", er); end
  endtask

  task automatic test_wait_states();
    logic sr, er; int nw, rc; logic [31:0] rd;
    xfer(1, 3'b010, 1'b0, 32'h8000_003C, 32'h0, 1'b1, sr, nw, rd, er, rc);
    $display("read id (3 waits): data=%h nwait=%0d err=%b", rd, nw, er);
    checks++; if (sr !== 1'b0) begin errors++; $display("FAIL ws_setup_ready got=%b exp=0", sr); end
    checks++; if (nw !== 3) begin errors++; $display("FAIL ws_nwait got=%0d exp=3", nw); end
    checks++; if (rd !== 32'hA9B0_0001) begin errors++; $display("FAIL ws_data got=%h exp=a9b00001", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL ws_err got=%b exp=0", er); end
  endtask

  task automatic test_errors();
    logic sr, er; int nw, rc; logic [31:0] rd;
    xfer(0, 3'b001, 1'b1, 32'h8000_003C, 32'h0000_0001, 1'b1, sr, nw, rd, er, rc);
    $display("write id reg: nwait=%0d err=%b", nw, er);
    checks++; if (nw !== 0 || er !== 1'b1) begin errors++; $display("FAIL err_wr_id got nwait=%0d err=%b exp nwait=0 err=1", nw, er); end
    xfer(0, 3'b001, 1'b1, 32'h8000_0002, 32'h0000_1111, 1'b1, sr, nw, rd, er, rc);
    $display("write misaligned: nwait=%0d err=%b", nw, er);
    checks++; if (nw !== 0 || er !== 1'b1) begin errors++; $display("FAIL err_wr_misalign got nwait=%0d err=%b exp nwait=0 err=1", nw, er); end
    xfer(0, 3'b001, 1'b0, 32'h9000_0000, 32'h0, 1'b1, sr, nw, rd, er, rc);
    $display("read out of window: data=%h nwait=%0d err=%b", rd, nw, er);
    checks++; if (nw !== 0 || er !== 1'b1) begin errors++; $display("FAIL err_rd_window got nwait=%0d err=%b exp nwait=0 err=1", nw, er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_rd_data got=%h exp=0", rd); end
    xfer(0, 3'b001, 1'b0, 32'h8000_0000, 32'h0, 1'b1, sr, nw, rd, er, rc);
    $display("read reg0 after errors: data=%h err=%b", rd, er);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL err_reg0_kept got=%h exp=deadbeef", rd); end
    xfer(0, 3'b001, 1'b0, 32'h8000_003C, 32'h0, 1'b1, sr, nw, rd, er, rc);
    $display("read id after errors: data=%h err=%b", rd, er);
    checks++; if (rd !== 32'hA9B0_0001 || er !== 1'b0) begin errors++; $display("FAIL err_id_kept got=%h err=%b exp=a9b00001 err=0", rd, er); end
  endtask

  task automatic test_select_abort();
    logic sr, er; int nw, rc; logic [31:0] rd;
    // Pselx[1] only: dut0 must stay silent.
    xfer(0, 3'b010, 1'b0, 32'h8000_0000, 32'h0, 1'b1, sr, nw, rd, er, rc);
    $display("unselected dut0: setup_ready=%b nwait=%0d", sr, nw);
    checks++; if (sr !== 1'b0) begin errors++; $display("FAIL nosel_setup_ready got=%b exp=0", sr); end
    checks++; if (nw !== -1) begin errors++; $display("FAIL nosel_ready got nwait=%0d exp=-1 (never ready)", nw); end
    step();
    // dut1: write, then deselect during the wait states.
    pselx = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8000_0008; pwdata = 32'h0000_AAAA;
    step();
    penable = 1'b1;
    @(negedge hclk);
    checks++; if (pready1 !== 1'b0) begin errors++; $display("FAIL abort_wait_ready got=%b exp=0", pready1); end
    step();
    drive_idle();
    @(negedge hclk);
    checks++; if (pready1 !== 1'b0) begin errors++; $display("FAIL abort_desel_ready got=%b exp=0", pready1); end
    step();
    xfer(1, 3'b010, 1'b0, 32'h8000_0008, 32'h0, 1'b1, sr, nw, rd, er, rc);
    $display("read after abort: data=%h nwait=%0d err=%b", rd, nw, er);
    checks++; if (nw !== 3) begin errors++; $display("FAIL abort_idle_nwait got=%0d exp=3", nw); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_no_write got=%h exp=0", rd); end
  endtask

  task automatic test_mid_reset();
    logic sr, er; int nw, rc; logic [31:0] rd;
    xfer(0, 3'b001, 1'b1, 32'h8000_0008, 32'h1234_5678, 1'b1, sr, nw, rd, er, rc);
    xfer(0, 3'b001, 1'b0, 32'h8000_0008, 32'h0, 1'b1, sr, nw, rd, er, rc);
    $display("read reg2 before reset: data=%h", rd);
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL mr_pre got=%h exp=12345678", rd); end
    pselx = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8000_0008; pwdata = 32'hFFFF_FFFF;
    step();
    penable = 1'b1;
    hresetn = 1'b0;
    step();
    @(negedge hclk);
    checks++; if (pready0 !== 1'b0 || pslverr0 !== 1'b0) begin errors++; $display("FAIL mr_resp got rdy=%b err=%b exp 0 0", pready0, pslverr0); end
    checks++; if (prdata0 !== 32'h0) begin errors++; $display("FAIL mr_prdata got=%h exp=0", prdata0); end
    checks++; if (regout0 !== 32'h0) begin errors++; $display("FAIL mr_regout got=%h exp=0", regout0); end
    step();
    drive_idle();
    hresetn = 1'b1;
    step();
    xfer(0, 3'b001, 1'b0, 32'h8000_0008, 32'h0, 1'b1, sr, nw, rd, er, rc);
    $display("read reg2 after reset: data=%h err=%b", rd, er);
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL mr_post got=%h err=%b exp=0 err=0", rd, er); end
  endtask

  task automatic test_back_to_back();
    logic sr, er; int nw, rc_w, rc_r; logic [31:0] rd;
    xfer(0, 3'b001, 1'b1, 32'h8000_0010, 32'h0000_0005, 1'b0, sr, nw, rd, er, rc_w);
    xfer(0, 3'b001, 1'b0, 32'h8000_0010, 32'h0, 1'b1, sr, nw, rd, er, rc_r);
    $display("back-to-back reg4: data=%h write_done=%0d read_done=%0d", rd, rc_w, rc_r);
    checks++; if (rd !== 32'h5 || er !== 1'b0) begin errors++; $display("FAIL b2b_data got=%h err=%b exp=5 err=0", rd, er); end
    checks++; if (rc_r !== rc_w + 2) begin errors++; $display("FAIL b2b_gap got=%0d exp=%0d", rc_r, rc_w + 2); end
  endtask

  initial begin
    hresetn = 1'b0;
    drive_idle();
    test_reset();
    test_write_read();
    test_wait_states();
    test_errors();
    test_select_abort();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
